// File: rtl/mrd_col_seq_pkg.sv
// Shared definitions for the MRD column-wise inverse sequencer.
package mrd_col_seq_pkg;

   // Sequencer states, in the order a full load+invert pass visits them.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SETUP = 3'd2,
      ST_RUN   = 3'd3,
      ST_CAP   = 3'd4,
      ST_OUT   = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // Length of the inverse-stage enable window for one column.
   function automatic int run_cycles(input int iter_num, input int iter_cyc);
      return iter_num * iter_cyc;
   endfunction

endpackage

// File: rtl/mrd_col_seq_onehot.sv
// One-hot vector generator: places val at element idx, zero elsewhere.
module onehot_vec_gen #(
   parameter int DIMENSION = 16,
   parameter int WIDTH     = 8
) (
   input  logic [$clog2(DIMENSION)-1:0] idx,
   input  logic signed [WIDTH-1:0]      val,
   output logic [DIMENSION*WIDTH-1:0]   vec
);

   // Decode idx into a single populated element slice.
   always_comb begin
      vec = '0;
      for (int i = 0; i < DIMENSION; i++) begin
         if (int'(idx) == i) begin
            vec[i*WIDTH +: WIDTH] = val;
         end
      end
   end

endmodule

// File: rtl/mrd_col_seq.sv
// Upstream sequencer for the MRD column-wise inverse stage: loads matrix A
// row by row, then drives the inverse stage once per column and emits each
// captured column of A^-1 over a valid/ready handshake.
module mrd_col_seq
   import mrd_col_seq_pkg::*;
#(
   parameter int DIMENSION = 16,
   parameter int WIDTH     = 8,
   parameter int ITER_NUM  = 2,
   parameter int ITER_CYC  = 4,
   parameter int INIT_VAL  = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [DIMENSION*WIDTH-1:0]          row_in,
   input  logic                                row_valid,
   output logic                                row_ready,
   output logic [DIMENSION*DIMENSION*WIDTH-1:0] a_bank,
   output logic [DIMENSION*WIDTH-1:0]          ej,
   output logic [DIMENSION*WIDTH-1:0]          m_init,
   output logic                                inv_start,
   output logic                                inv_en,
   input  logic [DIMENSION*WIDTH-1:0]          m_iter,
   output logic [DIMENSION*WIDTH-1:0]          col_data,
   output logic [$clog2(DIMENSION)-1:0]        col_idx,
   output logic                                col_valid,
   input  logic                                col_ready,
   output logic                                busy,
   output logic                                done
);

   localparam int IDX_W   = $clog2(DIMENSION);
   localparam int ROW_W   = DIMENSION * WIDTH;
   localparam int RUN_CYC = run_cycles(ITER_NUM, ITER_CYC);
   localparam int RUN_W   = $clog2(RUN_CYC + 1);

   localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(DIMENSION - 1);
   localparam logic [RUN_W-1:0]        LAST_RUN = RUN_W'(RUN_CYC - 1);
   localparam logic signed [WIDTH-1:0] ONE_W    = WIDTH'(1);
   localparam logic signed [WIDTH-1:0] INIT_W   = WIDTH'(INIT_VAL);

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   col_idx_nxt;
   logic [IDX_W-1:0]   row_cnt;
   logic [RUN_W-1:0]   run_cnt;
   logic [ROW_W-1:0]   ej_gen;
   logic [ROW_W-1:0]   m_init_gen;

   // Vectors are generated from the column index the FSM is about to use,
   // so the registered copies are already valid in the SETUP cycle.
   onehot_vec_gen #(.DIMENSION(DIMENSION), .WIDTH(WIDTH)) u_ej_gen (
      .idx (col_idx_nxt),
      .val (ONE_W),
      .vec (ej_gen)
   );

   onehot_vec_gen #(.DIMENSION(DIMENSION), .WIDTH(WIDTH)) u_minit_gen (
      .idx (col_idx_nxt),
      .val (INIT_W),
      .vec (m_init_gen)
   );

   // Next-state, next column index and state-decoded control outputs.
   always_comb begin
      state_nxt   = state;
      col_idx_nxt = col_idx;
      row_ready   = 1'b0;
      inv_start   = 1'b0;
      inv_en      = 1'b0;
      col_valid   = 1'b0;
      done        = 1'b0;
      busy        = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt   = ST_LOAD;
               col_idx_nxt = '0;
            end
         end
         ST_LOAD: begin
            row_ready = 1'b1;
            if (row_valid && (row_cnt == LAST_IDX)) begin
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            inv_start = 1'b1;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            inv_en = 1'b1;
            if (run_cnt == LAST_RUN) begin
               state_nxt = ST_CAP;
            end
         end
         ST_CAP: begin
            state_nxt = ST_OUT;
         end
         ST_OUT: begin
            col_valid = 1'b1;
            if (col_ready) begin
               if (col_idx == LAST_IDX) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt   = ST_SETUP;
                  col_idx_nxt = col_idx + IDX_W'(1);
               end
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register and column index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         col_idx <= '0;
      end else begin
         state   <= state_nxt;
         col_idx <= col_idx_nxt;
      end
   end

   // Row counter and matrix bank; rows are written only on an accepted handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt <= '0;
         a_bank  <= '0;
      end else if ((state == ST_IDLE) && start) begin
         row_cnt <= '0;
      end else if ((state == ST_LOAD) && row_valid) begin
         a_bank[int'(row_cnt)*ROW_W +: ROW_W] <= row_in;
         row_cnt <= row_cnt + IDX_W'(1);
      end
   end

   // Enable-window counter, cleared in SETUP and advanced through RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt <= '0;
      end else if (state == ST_SETUP) begin
         run_cnt <= '0;
      end else if (state == ST_RUN) begin
         run_cnt <= run_cnt + RUN_W'(1);
      end
   end

   // Unit vector and initial guess, latched on entry to SETUP and held for the column.
   always_ff @(posedge clk) begin
      if (rst) begin
         ej     <= '0;
         m_init <= '0;
      end else if (state_nxt == ST_SETUP) begin
         ej     <= ej_gen;
         m_init <= m_init_gen;
      end
   end

   // Capture the inverse-stage result once the enable window has closed.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_data <= '0;
      end else if (state == ST_CAP) begin
         col_data <= m_iter;
      end
   end

endmodule

// File: tb/tb_mrd_col_seq.sv
// Self-checking bench for mrd_col_seq with a stub inverse stage.
module tb_mrd_col_seq;

   localparam int D        = 16;
   localparam int W        = 8;
   localparam int ROW_W    = D * W;
   localparam int RUN_CYC  = 8;
   localparam int INIT_VAL = 1;
   localparam int COL_LAT  = 2 + RUN_CYC;
   localparam int RUN_TOT  = D * (3 + RUN_CYC);

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [ROW_W-1:0]      row_in;
   logic                  row_valid;
   logic                  row_ready;
   logic [D*ROW_W-1:0]    a_bank;
   logic [ROW_W-1:0]      ej;
   logic [ROW_W-1:0]      m_init;
   logic                  inv_start;
   logic                  inv_en;
   logic [ROW_W-1:0]      m_iter;
   logic [ROW_W-1:0]      col_data;
   logic [3:0]            col_idx;
   logic                  col_valid;
   logic                  col_ready;
   logic                  busy;
   logic                  done;

   mrd_col_seq #(.DIMENSION(D), .WIDTH(W), .ITER_NUM(2), .ITER_CYC(4), .INIT_VAL(INIT_VAL)) dut (
      .clk(clk), .rst(rst), .start(start), .row_in(row_in), .row_valid(row_valid),
      .row_ready(row_ready), .a_bank(a_bank), .ej(ej), .m_init(m_init),
      .inv_start(inv_start), .inv_en(inv_en), .m_iter(m_iter), .col_data(col_data),
      .col_idx(col_idx), .col_valid(col_valid), .col_ready(col_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Stub inverse stage: echoes m_init only after exactly RUN_CYC enabled cycles.
   logic [ROW_W-1:0] stub_base = '0;
   int               stub_en   = 0;
   always @(posedge clk) begin
      if (inv_start) begin
         stub_base <= m_init;
         stub_en   <= 0;
      end else if (inv_en) begin
         stub_en <= stub_en + 1;
      end
   end
   assign m_iter = (stub_en == RUN_CYC) ? stub_base : ~stub_base;

   typedef struct {
      int               idx;
      logic [ROW_W-1:0] data;
   } sb_t;
   sb_t sb[$];

   int n_pass   = 0;
   int n_total  = 0;
   int cyc_cnt  = 0;
   int done_cnt = 0;
   logic [ROW_W-1:0] exp_rows [D];

   task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [ROW_W-1:0] onehot(input int k, input logic [W-1:0] v);
      logic [ROW_W-1:0] vec;
      vec = '0;
      vec[k*W +: W] = v;
      return vec;
   endfunction

   function automatic logic [ROW_W-1:0] row_val(input int r, input int kind);
      logic [ROW_W-1:0] vec;
      if (kind == 0) begin
         vec = onehot(r, 8'd1);
      end else begin
         vec = '0;
         for (int i = 0; i < D; i++) vec[i*W +: W] = W'(r*16 + i + 3);
      end
      return vec;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Monitor: column latency, enable window length, scoreboard pops, done pulses.
   initial begin
      int  setup_cyc = 0;
      int  en_cnt = 0;
      bit  in_col = 0;
      sb_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_col = 0;
         end else begin
            if (inv_start) begin
               setup_cyc = cyc_cnt;
               en_cnt    = 0;
               in_col    = 1;
            end
            if (inv_en) en_cnt++;
            if (col_valid && in_col) begin
               check("col_latency", ROW_W'(cyc_cnt - setup_cyc), ROW_W'(COL_LAT));
               check("col_en_cycles", ROW_W'(en_cnt), ROW_W'(RUN_CYC));
               in_col = 0;
            end
            if (col_valid && col_ready) begin
               if (sb.size() == 0) begin
                  n_total++;
                  $display("FAIL sb_underflow: got column %0d with no expected entry", col_idx);
               end else begin
                  e = sb.pop_front();
                  check("col_idx", ROW_W'(col_idx), ROW_W'(e.idx));
                  check("col_data", col_data, e.data);
               end
            end
            if (done) done_cnt++;
         end
      end
   end

   task automatic push_cols();
      sb_t e;
      for (int k = 0; k < D; k++) begin
         e.idx  = k;
         e.data = onehot(k, W'(INIT_VAL));
         sb.push_back(e);
      end
      done_cnt = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, ROW_W'({row_ready, inv_en, inv_start, col_valid, busy, done}), '0);
      check({tag, "_ej"}, ej, '0);
      check({tag, "_minit"}, m_init, '0);
      check({tag, "_coldata"}, col_data, '0);
      check({tag, "_colidx"}, ROW_W'(col_idx), '0);
      check({tag, "_bank"}, ROW_W'(|a_bank), '0);
   endtask

   task automatic do_start();
      push_cols();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", ROW_W'({busy, row_ready}), ROW_W'(2'b11));
      check("start_colidx", ROW_W'(col_idx), '0);
   endtask

   // Load rows with valid gaps on load cycles 3 and 7; ends in SETUP.
   task automatic load_matrix(input int kind);
      int acc = 0;
      int cyc = 0;
      for (int r = 0; r < D; r++) exp_rows[r] = row_val(r, kind);
      while (acc < D && cyc < 40) begin
         check("load_ready", ROW_W'(row_ready), ROW_W'(1));
         if (cyc == 3 || cyc == 7) begin
            row_valid = 1'b0;
            row_in    = {ROW_W{1'b1}};
         end else begin
            row_valid = 1'b1;
            row_in    = exp_rows[acc];
            acc++;
         end
         tick();
         cyc++;
      end
      row_valid = 1'b0;
      row_in    = '0;
      check("load_cycles", ROW_W'(cyc), ROW_W'(D + 2));
      check("setup_ctl", ROW_W'({inv_start, inv_en, row_ready}), ROW_W'(3'b100));
      check("setup_ej", ej, onehot(0, 8'd1));
      check("setup_minit", m_init, onehot(0, W'(INIT_VAL)));
      check("bank_row5", a_bank[5*ROW_W +: ROW_W], exp_rows[5]);
   endtask

   // Drive columns until done; mode 1 adds back-pressure and ignored-input pokes.
   task automatic run_columns(input int mode, output int cycles);
      int hold = 0;
      bit held3 = 0, poked_row = 0, poked_start = 0;
      logic cr;
      cycles = 0;
      while (!done && cycles < 600) begin
         start = 1'b0;
         row_valid = 1'b0;
         row_in = '0;
         cr = 1'b1;
         if (mode == 1) begin
            if (col_valid && col_idx == 4'd3 && !held3) begin
               held3 = 1;
               hold  = 5;
            end
            if (hold > 0) begin
               check("hold_valid", ROW_W'({col_valid, inv_en}), ROW_W'(2'b10));
               check("hold_data", col_data, onehot(3, W'(INIT_VAL)));
               check("hold_idx", ROW_W'(col_idx), ROW_W'(3));
               hold--;
               cr = 1'b0;
            end else if (col_valid && col_idx == 4'd5 && !poked_row) begin
               poked_row = 1;
               row_valid = 1'b1;
               row_in    = {ROW_W{1'b1}};
               cr        = 1'b0;
            end
            if (inv_en && col_idx == 4'd5 && !poked_start) begin
               poked_start = 1;
               start       = 1'b1;
            end
         end
         col_ready = cr;
         tick();
         cycles++;
      end
      start = 1'b0;
      row_valid = 1'b0;
      check("run_done_seen", ROW_W'(done), ROW_W'(1));
   endtask

   task automatic end_of_run(input string tag);
      tick();
      check({tag, "_idle"}, ROW_W'({done, busy}), '0);
      check({tag, "_lastidx"}, ROW_W'(col_idx), ROW_W'(D - 1));
      check({tag, "_donecnt"}, ROW_W'(done_cnt), ROW_W'(1));
      check({tag, "_sbempty"}, ROW_W'(sb.size()), '0);
      for (int r = 0; r < D; r++) check($sformatf("%s_bank%0d", tag, r), a_bank[r*ROW_W +: ROW_W], exp_rows[r]);
   endtask

   typedef struct {
      logic rst;
      logic start;
      logic row_valid;
      logic exp_busy;
      logic exp_row_ready;
   } vec_t;

   initial begin
      vec_t tbl [6];
      int   cycles;
      rst = 1'b1; start = 1'b0; row_valid = 1'b0; row_in = '0; col_ready = 1'b0;
      tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      // Reset, idle and first start from the vector table.
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].start && !tbl[i].rst) push_cols();
         rst       = tbl[i].rst;
         start     = tbl[i].start;
         row_valid = tbl[i].row_valid;
         row_in    = {ROW_W{1'b1}};
         tick();
         check($sformatf("vec%0d_busy", i), ROW_W'(busy), ROW_W'(tbl[i].exp_busy));
         check($sformatf("vec%0d_ready", i), ROW_W'(row_ready), ROW_W'(tbl[i].exp_row_ready));
         if (i == 3) check_zero("reset");
      end
      start = 1'b0;
      check("load_colidx", ROW_W'(col_idx), '0);

      // Identity matrix, consumer always ready.
      load_matrix(0);
      run_columns(0, cycles);
      check("run0_cycles", ROW_W'(cycles), ROW_W'(RUN_TOT));
      end_of_run("run0");

      // Patterned matrix with back-pressure and ignored start/row_valid.
      do_start();
      load_matrix(1);
      run_columns(1, cycles);
      end_of_run("run1");

      // Abort in RUN at column 7.
      do_start();
      load_matrix(0);
      cycles = 0;
      col_ready = 1'b1;
      while (!(inv_en && col_idx == 4'd7) && cycles < 400) begin
         tick();
         cycles++;
      end
      check("abort_reached", ROW_W'({inv_en, col_idx}), ROW_W'({1'b1, 4'd7}));
      rst = 1'b1;
      tick();
      check_zero("abort");
      rst = 1'b0;
      sb.delete();
      tick();
      check_zero("abort_idle");

      // Restart after abort.
      do_start();
      load_matrix(0);
      run_columns(0, cycles);
      check("run3_cycles", ROW_W'(cycles), ROW_W'(RUN_TOT));
      end_of_run("run3");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
